// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package reset_seq_pkg;

    localparam int unsigned MAX_STAGES = 8;

    typedef enum logic [2:0] {
        HOLD,
        WAIT_ACK,
        GAP,
        RUN,
        FAULT
    } rseq_state_t;

    // Width needed to hold the largest of the three cycle limits.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Staged reset release for the datapath blocks: holds all stages in reset, then releases
// them one at a time in index order, waiting for each stage's ready acknowledge.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  soft_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  all_ready,
    output logic                  fault,
    output logic [2:0]            cur_stage
);

    localparam int unsigned CntW = cnt_width(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT);
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
    localparam logic [CntW-1:0] AckLast  = CntW'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);
    localparam logic [2:0]      LastStage = 3'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] AllRst = {NUM_STAGES{1'b1}};

    rseq_state_t           state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] stage_rst_d;
    logic                  all_ready_d;
    logic                  fault_d;
    logic [2:0]            cur_stage_d;
    logic [2:0]            next_stage;
    logic [MAX_STAGES-1:0] ack_ext;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stage_rst_d = stage_rst;
        all_ready_d = all_ready;
        fault_d     = fault;
        cur_stage_d = cur_stage;
        next_stage  = cur_stage + 3'd1;
        ack_ext     = '0;
        ack_ext[NUM_STAGES-1:0] = stage_ack;

        if (soft_rst_req) begin
            // Soft reset outranks ack, timeout and counter expiry on the same edge.
            state_d     = HOLD;
            cnt_d       = '0;
            stage_rst_d = AllRst;
            all_ready_d = 1'b0;
            fault_d     = 1'b0;
            cur_stage_d = 3'd0;
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (cnt_q == HoldLast) begin
                        stage_rst_d[0] = 1'b0;
                        state_d        = WAIT_ACK;
                        cnt_d          = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (ack_ext[cur_stage]) begin
                        cnt_d = '0;
                        if (cur_stage == LastStage) begin
                            all_ready_d = 1'b1;
                            state_d     = RUN;
                        end else begin
                            state_d = GAP;
                        end
                    end else if (ACK_TIMEOUT != 0) begin
                        if (cnt_q == AckLast) begin
                            fault_d     = 1'b1;
                            stage_rst_d = AllRst;
                            state_d     = FAULT;
                            cnt_d       = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (cnt_q == GapLast) begin
                        cur_stage_d = next_stage;
                        stage_rst_d = stage_rst & ~(NUM_STAGES'(1) << next_stage);
                        state_d     = WAIT_ACK;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!(&stage_ack)) begin
                        fault_d     = 1'b1;
                        all_ready_d = 1'b0;
                        stage_rst_d = AllRst;
                        state_d     = FAULT;
                    end
                end
                FAULT: begin
                    // cur_stage left untouched so the failing index stays visible.
                    stage_rst_d = AllRst;
                    fault_d     = 1'b1;
                end
                default: begin
                    state_d     = HOLD;
                    cnt_d       = '0;
                    stage_rst_d = AllRst;
                    all_ready_d = 1'b0;
                    fault_d     = 1'b0;
                    cur_stage_d = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            stage_rst <= AllRst;
            all_ready <= 1'b0;
            fault     <= 1'b0;
            cur_stage <= 3'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stage_rst <= stage_rst_d;
            all_ready <= all_ready_d;
            fault     <= fault_d;
            cur_stage <= cur_stage_d;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: release timing, timeout, soft reset, RUN fault, async reset.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       soft_rst_req;
    logic [2:0] stage_ack;
    logic [2:0] stage_rst;
    logic       all_ready;
    logic       fault;
    logic [2:0] cur_stage;

    int tests  = 0;
    int failed = 0;

    reset_sequencer #(
        .NUM_STAGES  (3),
        .HOLD_CYCLES (16),
        .GAP_CYCLES  (4),
        .ACK_TIMEOUT (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .soft_rst_req (soft_rst_req),
        .stage_ack    (stage_ack),
        .stage_rst    (stage_rst),
        .all_ready    (all_ready),
        .fault        (fault),
        .cur_stage    (cur_stage)
    );

    always #5 clk = ~clk;

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic soft_pulse();
        soft_rst_req = 1'b1;
        edges(1);
        soft_rst_req = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        soft_rst_req = 1'b0;
        stage_ack    = 3'b111;
        edges(3);
        check("rst_stage_rst", 32'(stage_rst), 32'h7);
        check("rst_all_ready", 32'(all_ready), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_cur_stage", 32'(cur_stage), 32'h0);

        // Test 1: all acks high, release rst.
        rst = 1'b0;
        edges(15);
        check("t1_e15_stage_rst", 32'(stage_rst), 32'h7);
        edges(1);
        check("t1_e16_stage_rst", 32'(stage_rst), 32'h6);
        edges(4);
        check("t1_e20_stage_rst", 32'(stage_rst), 32'h6);
        edges(1);
        check("t1_e21_stage_rst", 32'(stage_rst), 32'h4);
        check("t1_e21_cur_stage", 32'(cur_stage), 32'h1);
        edges(4);
        check("t1_e25_stage_rst", 32'(stage_rst), 32'h4);
        edges(1);
        check("t1_e26_stage_rst", 32'(stage_rst), 32'h0);
        check("t1_e26_all_ready", 32'(all_ready), 32'h0);
        edges(1);
        check("t1_e27_all_ready", 32'(all_ready), 32'h1);
        check("t1_e27_cur_stage", 32'(cur_stage), 32'h2);

        // Test 3: soft reset in RUN, sequence repeats relative to the pulse.
        soft_pulse();
        check("t3_pulse_stage_rst", 32'(stage_rst), 32'h7);
        check("t3_pulse_all_ready", 32'(all_ready), 32'h0);
        edges(15);
        check("t3_e15_stage_rst", 32'(stage_rst), 32'h7);
        edges(1);
        check("t3_e16_stage_rst", 32'(stage_rst), 32'h6);
        edges(10);
        check("t3_e26_stage_rst", 32'(stage_rst), 32'h0);
        check("t3_e26_all_ready", 32'(all_ready), 32'h0);
        edges(1);
        check("t3_e27_all_ready", 32'(all_ready), 32'h1);

        // Test 4: one-cycle drop of stage_ack[0] in RUN.
        stage_ack = 3'b110;
        edges(1);
        stage_ack = 3'b111;
        check("t4_fault", 32'(fault), 32'h1);
        check("t4_stage_rst", 32'(stage_rst), 32'h7);
        check("t4_all_ready", 32'(all_ready), 32'h0);
        edges(3);
        check("t4_fault_held", 32'(fault), 32'h1);
        check("t4_cur_frozen", 32'(cur_stage), 32'h2);
        soft_pulse();
        check("t4_soft_clears_fault", 32'(fault), 32'h0);
        check("t4_soft_cur_stage", 32'(cur_stage), 32'h0);
        edges(26);
        check("t4_reseq_e26_ready", 32'(all_ready), 32'h0);
        edges(1);
        check("t4_reseq_all_ready", 32'(all_ready), 32'h1);

        // Test 2: stage_ack[1] stuck low -> timeout.
        stage_ack = 3'b101;
        soft_pulse();
        edges(21);
        check("t2_stage1_released", 32'(stage_rst), 32'h4);
        edges(31);
        check("t2_e31_fault", 32'(fault), 32'h0);
        check("t2_e31_stage_rst", 32'(stage_rst), 32'h4);
        edges(1);
        check("t2_e32_fault", 32'(fault), 32'h1);
        check("t2_e32_cur_stage", 32'(cur_stage), 32'h1);
        check("t2_e32_stage_rst", 32'(stage_rst), 32'h7);
        check("t2_e32_all_ready", 32'(all_ready), 32'h0);

        // Test 5: async rst in the middle of the GAP after stage 1 acks.
        stage_ack = 3'b111;
        soft_pulse();
        edges(23);
        check("t5_gap_stage_rst", 32'(stage_rst), 32'h4);
        check("t5_gap_cur_stage", 32'(cur_stage), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_stage_rst", 32'(stage_rst), 32'h7);
        check("t5_async_cur_stage", 32'(cur_stage), 32'h0);
        check("t5_async_all_ready", 32'(all_ready), 32'h0);
        check("t5_async_fault", 32'(fault), 32'h0);

        // Test 6: soft reset on the same edge stage_ack[2] rises.
        edges(1);
        stage_ack = 3'b011;
        rst       = 1'b0;
        edges(28);
        check("t6_wait_stage_rst", 32'(stage_rst), 32'h0);
        check("t6_wait_all_ready", 32'(all_ready), 32'h0);
        stage_ack = 3'b111;
        soft_pulse();
        check("t6_pulse_all_ready", 32'(all_ready), 32'h0);
        check("t6_pulse_stage_rst", 32'(stage_rst), 32'h7);
        check("t6_pulse_cur_stage", 32'(cur_stage), 32'h0);
        edges(15);
        check("t6_hold_e15", 32'(stage_rst), 32'h7);
        edges(1);
        check("t6_hold_e16", 32'(stage_rst), 32'h6);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
